axi_mem_responder: RTL

Memory-side responder for the cache-block traffic issued by the core datapath. It accepts AXI4-style incrementing bursts (a 512-bit block equals 8 × 64-bit beats), serves instruction/data cache refills from a word-addressed backing store, and absorbs dirty-block write-backs. It handles one transaction at a time, with configurable read latency, and is used as the simulation/FPGA memory model behind the core's AXI master.

---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_mem_array.sv | 30 +++
 rtl/axi_mem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI memory responder: response codes,
// burst length width and the responder state encoding.
package axi_pkg;

    localparam int AXI_LEN_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_DATA,
        ST_WR_RESP
    } state_t;

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed backing store: combinational read port, byte-enabled
// synchronous write port. Contents are deliberately not reset.
module axi_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_W    = 12
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [DEPTH_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic [DEPTH_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<DEPTH_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_wstrb[b]) begin
                    mem_q[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// Single-transaction AXI4 INCR burst responder in front of a word store,
// used as the memory model behind the core's cache refill/write-back port.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_DEPTH_W  = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_ar_valid,
    output logic                    o_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ar_addr,
    input  logic [AXI_LEN_W-1:0]    i_ar_len,
    output logic                    o_r_valid,
    input  logic                    i_r_ready,
    output logic [DATA_WIDTH-1:0]   o_r_data,
    output logic                    o_r_last,
    output logic [1:0]              o_r_resp,
    input  logic                    i_aw_valid,
    output logic                    o_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   i_aw_addr,
    input  logic [AXI_LEN_W-1:0]    i_aw_len,
    input  logic                    i_w_valid,
    output logic                    o_w_ready,
    input  logic [DATA_WIDTH-1:0]   i_w_data,
    input  logic [DATA_WIDTH/8-1:0] i_w_strb,
    input  logic                    i_w_last,
    output logic                    o_b_valid,
    input  logic                    i_b_ready,
    output logic [1:0]              o_b_resp,
    output state_t                  o_dbg_state
);

    localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    // A transfer happens on a rising edge where valid and ready are both high.
    // Every ready/valid driven here is registered; readies rise only in IDLE.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (MEM_DEPTH_W + 3)) != '0;
    endfunction

    state_t                   state_q;
    logic [MEM_DEPTH_W-1:0]   idx_q;
    logic [AXI_LEN_W-1:0]     len_q;
    logic [AXI_LEN_W-1:0]     beat_q;
    logic                     err_q;
    logic [LAT_W-1:0]         lat_q;
    logic                     ar_ready_q, aw_ready_q, w_ready_q, b_valid_q;
    logic                     r_valid_q, r_last_q;
    logic [1:0]               r_resp_q, b_resp_q;
    logic [DATA_WIDTH-1:0]    r_data_q;

    logic [MEM_DEPTH_W-1:0]   ar_idx, aw_idx, rd_idx;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     ar_err, ar_hs, aw_hs, r_hs, w_hs;
    logic                     beat_at_len, w_end, w_mismatch, mem_we;

    assign ar_idx      = i_ar_addr[MEM_DEPTH_W+2:3];
    assign aw_idx      = i_aw_addr[MEM_DEPTH_W+2:3];
    assign ar_err      = out_of_range(i_ar_addr);
    assign ar_hs       = ar_ready_q && i_ar_valid;
    assign aw_hs       = aw_ready_q && i_aw_valid;
    assign r_hs        = r_valid_q && i_r_ready;
    assign w_hs        = w_ready_q && i_w_valid;
    assign beat_at_len = (beat_q == len_q);
    assign w_end       = i_w_last || beat_at_len;
    assign w_mismatch  = i_w_last != beat_at_len;
    assign mem_we      = w_hs && !err_q;

    // Read port points at whichever word will be loaded into r_data_q next edge.
    always_comb begin
        rd_idx = ar_idx;
        case (state_q)
            ST_RD_WAIT:  rd_idx = idx_q;
            ST_RD_BURST: rd_idx = idx_q + 1'b1;
            default:     rd_idx = ar_idx;
        endcase
    end

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_W    (MEM_DEPTH_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (idx_q),
        .i_wdata (i_w_data),
        .i_wstrb (i_w_strb),
        .i_raddr (rd_idx),
        .o_rdata (mem_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            lat_q      <= '0;
            ar_ready_q <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (aw_hs) begin
                        aw_ready_q <= 1'b0;
                        ar_ready_q <= 1'b0;
                        idx_q      <= aw_idx;
                        len_q      <= i_aw_len;
                        beat_q     <= '0;
                        err_q      <= out_of_range(i_aw_addr);
                        w_ready_q  <= 1'b1;
                        state_q    <= ST_WR_DATA;
                    end else if (ar_hs) begin
                        aw_ready_q <= 1'b0;
                        ar_ready_q <= 1'b0;
                        idx_q      <= ar_idx;
                        len_q      <= i_ar_len;
                        beat_q     <= '0;
                        err_q      <= ar_err;
                        lat_q      <= LAT_W'(READ_LATENCY);
                        if (READ_LATENCY == 0) begin
                            r_valid_q <= 1'b1;
                            r_data_q  <= ar_err ? '0 : mem_rdata;
                            r_last_q  <= (i_ar_len == '0);
                            r_resp_q  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                            state_q   <= ST_RD_BURST;
                        end else begin
                            state_q   <= ST_RD_WAIT;
                        end
                    end else begin
                        // Write-back wins so the victim lands before the refill.
                        aw_ready_q <= i_aw_valid;
                        ar_ready_q <= !i_aw_valid && i_ar_valid;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_q == LAT_W'(1)) begin
                        r_valid_q <= 1'b1;
                        r_data_q  <= err_q ? '0 : mem_rdata;
                        r_last_q  <= (len_q == '0);
                        r_resp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                        state_q   <= ST_RD_BURST;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                ST_RD_BURST: begin
                    if (r_hs) begin
                        if (beat_at_len) begin
                            r_valid_q <= 1'b0;
                            r_last_q  <= 1'b0;
                            r_resp_q  <= RESP_OKAY;
                            r_data_q  <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            beat_q   <= beat_q + 1'b1;
                            r_data_q <= err_q ? '0 : mem_rdata;
                            r_last_q <= ((beat_q + AXI_LEN_W'(1)) == len_q);
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        idx_q  <= idx_q + 1'b1;
                        beat_q <= beat_q + 1'b1;
                        if (w_end) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            b_resp_q  <= (err_q || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
                            state_q   <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (i_b_ready) begin
                        b_valid_q <= 1'b0;
                        b_resp_q  <= RESP_OKAY;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ar_ready  = ar_ready_q;
    assign o_aw_ready  = aw_ready_q;
    assign o_w_ready   = w_ready_q;
    assign o_b_valid   = b_valid_q;
    assign o_b_resp    = b_resp_q;
    assign o_r_valid   = r_valid_q;
    assign o_r_data    = r_data_q;
    assign o_r_last    = r_last_q;
    assign o_r_resp    = r_resp_q;
    assign o_dbg_state = state_q;

endmodule
